// File: rtl/aes192_iter_ctrl.sv
// rtl/aes192_iter_ctrl.sv - iterative AES-192 encryptor, one round per clock, on-the-fly key expansion
// Optional debug ports (dbg_round, dbg_state) enabled by `define AES192_ITER_DBG_EN
module aes192_iter_ctrl #(
  parameter int NR = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [191:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
`ifdef AES192_ITER_DBG_EN
  ,
  output logic [3:0]   dbg_round,
  output logic [1:0]   dbg_state
`endif
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  typedef logic [5:0][31:0] grp_t;

  localparam logic [3:0] LAST = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t, r;
    t = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic grp_t expand(input grp_t p, input logic [7:0] rcon);
    grp_t n;
    n[0] = p[0] ^ sub_word({p[5][23:0], p[5][31:24]}) ^ {rcon, 24'h000000};
    for (int j = 1; j < 6; j++) n[j] = n[j-1] ^ p[j];
    return n;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [15:0][7:0] b, h;
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    logic [31:0] col;
    b = '0;
    h = '0;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) h[4*c+w] = b[4*((c+w)%4)+w];
    for (int c = 0; c < 4; c++) begin
      a0 = h[4*c];
      a1 = h[4*c+1];
      a2 = h[4*c+2];
      a3 = h[4*c+3];
      if (last) col = {a0, a1, a2, a3};
      else col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      r[127-32*c -: 32] = col ^ rk[127-32*c -: 32];
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        rnd_q, rnd_d;
  logic [127:0]      st_q, st_d;
  logic [11:0][31:0] kb_q, kb_d;
  logic [7:0]        rcon_q, rcon_d;
  logic [127:0]      out_data_q, out_data_d;

  grp_t         key_grp, exp_in, exp_out;
  logic [7:0]   exp_rcon;
  logic [127:0] rk, round_out;
  logic         last_round, slide;

  always_comb begin
    for (int j = 0; j < 6; j++) key_grp[j] = in_key[191-32*j -: 32];
  end

  // kb_q holds w[6m..6m+11]; the window advances by six words after every round with r mod 3 != 0
  always_comb begin
    rk    = {kb_q[0], kb_q[1], kb_q[2], kb_q[3]};
    slide = 1'b0;
    case (rnd_q)
      4'd1, 4'd4, 4'd7, 4'd10: begin
        rk    = {kb_q[4], kb_q[5], kb_q[6], kb_q[7]};
        slide = 1'b1;
      end
      4'd2, 4'd5, 4'd8, 4'd11: begin
        rk    = {kb_q[2], kb_q[3], kb_q[4], kb_q[5]};
        slide = 1'b1;
      end
      default: ;
    endcase
  end

  assign last_round = (rnd_q == LAST);
  assign exp_in     = (state_q == S_IDLE) ? key_grp : grp_t'(kb_q[11:6]);
  assign exp_rcon   = (state_q == S_IDLE) ? 8'h01 : rcon_q;
  assign exp_out    = expand(exp_in, exp_rcon);
  assign round_out  = aes_round(st_q, rk, last_round);

  always_comb begin
    state_d    = state_q;
    rnd_d      = rnd_q;
    st_d       = st_q;
    kb_d       = kb_q;
    rcon_d     = rcon_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        rnd_d = 4'd0;
        if (in_valid) begin
          st_d        = in_data ^ in_key[191:64];
          kb_d[5:0]   = key_grp;
          kb_d[11:6]  = exp_out;
          rcon_d      = 8'h02;
          rnd_d       = 4'd1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        st_d = round_out;
        if (last_round) begin
          out_data_d = round_out;
          state_d    = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
          if (slide) begin
            kb_d[5:0]  = kb_q[11:6];
            kb_d[11:6] = exp_out;
            rcon_d     = {rcon_q[6:0], 1'b0};
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
          rnd_d   = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rnd_q      <= 4'd0;
      st_q       <= '0;
      kb_q       <= '0;
      rcon_q     <= 8'h00;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rnd_q      <= rnd_d;
      st_q       <= st_d;
      kb_q       <= kb_d;
      rcon_q     <= rcon_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;

`ifdef AES192_ITER_DBG_EN
  assign dbg_round = rnd_q;
  assign dbg_state = state_q;
`endif

endmodule
